// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared definitions: FSM states, datapath select codes,
// MIPS opcode/funct values and the decoded instruction bundle.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_ERR    = 3'b101
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] BSEL_RT    = 2'b00;
  localparam logic [1:0] BSEL_IMM   = 2'b01;
  localparam logic [1:0] BSEL_SHAMT = 2'b10;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;
  localparam logic [1:0] WD_LUI = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    IC_NOP  = 4'd0,
    IC_ALUR = 4'd1,
    IC_ALUI = 4'd2,
    IC_LUI  = 4'd3,
    IC_LW   = 4'd4,
    IC_SW   = 4'd5,
    IC_BEQ  = 4'd6,
    IC_BNE  = 4'd7,
    IC_J    = 4'd8,
    IC_JAL  = 4'd9,
    IC_JR   = 4'd10,
    IC_JALR = 4'd11
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [3:0] alu_op;
    logic [1:0] b_sel;
    logic       a_rt;
    logic       ext;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl instruction decode: Op/Funct to instruction class and
// ALU controls. Unrecognised encodings decode as IC_NOP.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Class and ALU control lookup
  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_RTYPE: begin
        dec_o.cls = IC_ALUR;
        case (funct_i)
          FN_ADD, FN_ADDU: dec_o.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_o.alu_op = ALU_SUB;
          FN_AND:  dec_o.alu_op = ALU_AND;
          FN_OR:   dec_o.alu_op = ALU_OR;
          FN_XOR:  dec_o.alu_op = ALU_XOR;
          FN_NOR:  dec_o.alu_op = ALU_NOR;
          FN_SLT:  dec_o.alu_op = ALU_SLT;
          FN_SLTU: dec_o.alu_op = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_o.b_sel = BSEL_SHAMT;
            dec_o.a_rt  = 1'b1;
            case (funct_i)
              FN_SLL:  dec_o.alu_op = ALU_SLL;
              FN_SRL:  dec_o.alu_op = ALU_SRL;
              default: dec_o.alu_op = ALU_SRA;
            endcase
          end
          FN_JR:   dec_o.cls = IC_JR;
          FN_JALR: dec_o.cls = IC_JALR;
          default: dec_o.cls = IC_NOP;
        endcase
      end
      OP_ADDI: begin
        dec_o.cls    = IC_ALUI;
        dec_o.alu_op = ALU_ADD;
        dec_o.b_sel  = BSEL_IMM;
        dec_o.ext    = 1'b1;
      end
      OP_SLTI: begin
        dec_o.cls    = IC_ALUI;
        dec_o.alu_op = ALU_SLT;
        dec_o.b_sel  = BSEL_IMM;
        dec_o.ext    = 1'b1;
      end
      OP_ANDI: begin
        dec_o.cls    = IC_ALUI;
        dec_o.alu_op = ALU_AND;
        dec_o.b_sel  = BSEL_IMM;
      end
      OP_ORI: begin
        dec_o.cls    = IC_ALUI;
        dec_o.alu_op = ALU_OR;
        dec_o.b_sel  = BSEL_IMM;
      end
      OP_LUI: begin
        dec_o.cls    = IC_LUI;
        dec_o.alu_op = ALU_LUI;
        dec_o.b_sel  = BSEL_IMM;
      end
      OP_LW, OP_SW: begin
        dec_o.cls    = (op_i == OP_LW) ? IC_LW : IC_SW;
        dec_o.alu_op = ALU_ADD;
        dec_o.b_sel  = BSEL_IMM;
        dec_o.ext    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.cls    = (op_i == OP_BEQ) ? IC_BEQ : IC_BNE;
        dec_o.alu_op = ALU_SUB;
      end
      OP_J:    dec_o.cls = IC_J;
      OP_JAL:  dec_o.cls = IC_JAL;
      default: dec_o.cls = IC_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller with memory-wait watchdog.
// Optional MC_CTRL_RETIRE_CNT_EN adds the retire_cnt output.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] ALUSrc,
  output logic       ASrc,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
`ifdef MC_CTRL_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic       bus_err
);

  localparam bit WD_EN = (TO_MAX != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            berr_q, berr_d;
  logic            waiting;
  dec_t            dec;

  mc_ctrl_dec u_dec (
    .op_i    (Op),
    .funct_i (Funct),
    .dec_o   (dec)
  );

  // Next state plus watchdog; the counter clears whenever state moves
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    berr_d  = berr_q;
    waiting = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) state_d = S_DECODE;
        else            waiting = 1'b1;
      end
      S_DECODE: begin
        case (dec.cls)
          IC_J, IC_JAL, IC_JR, IC_JALR: state_d = S_FETCH;
          default:                      state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (dec.cls)
          IC_BEQ, IC_BNE: state_d = S_FETCH;
          IC_LW, IC_SW:   state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)
          state_d = (dec.cls == IC_LW) ? S_WB : S_FETCH;
        else
          waiting = 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
    if (waiting) begin
      if (WD_EN && cnt_q == TO_LAST) begin
        state_d = S_ERR;
        berr_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  // State, watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Count every return to FETCH; a reset never counts as a retire
  always_ff @(posedge clk) begin
    if (rst)
      retire_q <= '0;
    else if (state_d == S_FETCH && state_q != S_FETCH)
      retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = rst ? 32'd0 : retire_q;
`endif

  assign state   = rst ? 3'b000 : state_q;
  assign bus_err = rst ? 1'b0 : berr_q;

  // Datapath strobes decoded from state and instruction
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUOp    = ALU_ADD;
    NPCOp    = NPC_PC4;
    ALUSrc   = BSEL_RT;
    ASrc     = 1'b0;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    if (!rst) begin
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
        ALUOp  = dec.alu_op;
        ALUSrc = dec.b_sel;
        ASrc   = dec.a_rt;
        EXTOp  = dec.ext;
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
          PCWrite  = imem_ready;
        end
        S_DECODE: begin
          case (dec.cls)
            IC_J: begin
              PCWrite = 1'b1;
              NPCOp   = NPC_J;
            end
            IC_JAL: begin
              PCWrite  = 1'b1;
              NPCOp    = NPC_J;
              RegWrite = 1'b1;
              GPRSel   = GPR_RA;
              WDSel    = WD_PC;
            end
            IC_JR: begin
              PCWrite = 1'b1;
              NPCOp   = NPC_JR;
            end
            IC_JALR: begin
              PCWrite  = 1'b1;
              NPCOp    = NPC_JR;
              RegWrite = 1'b1;
              GPRSel   = GPR_RD;
              WDSel    = WD_PC;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (dec.cls == IC_BEQ) begin
            PCWrite = Zero;
            NPCOp   = NPC_BR;
          end else if (dec.cls == IC_BNE) begin
            PCWrite = ~Zero;
            NPCOp   = NPC_BR;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          MemWrite = (dec.cls == IC_SW);
        end
        S_WB: begin
          RegWrite = (dec.cls != IC_NOP);
          if (dec.cls inside {IC_ALUI, IC_LUI, IC_LW})
            GPRSel = GPR_RT;
          if (dec.cls == IC_LW)
            WDSel = WD_MEM;
          else if (dec.cls == IC_LUI)
            WDSel = WD_LUI;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream against a per-instruction
// cycle-sequence model, checked by a scoreboard monitor.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int TOM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = '0, Funct = '0;
  logic       Zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, IRWrite, PCWrite, RegWrite;
  logic       MemWrite, EXTOp, ASrc, bus_err;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, ALUSrc, GPRSel, WDSel;
  logic [2:0] state;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  mc_ctrl #(.TO_W(8), .TO_MAX(TOM)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrc(ALUSrc),
    .ASrc(ASrc), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
`ifdef MC_CTRL_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq, dreq, irw, pcw, rw, mw, ext;
    logic [3:0] alu;
    logic [1:0] npc, bsel;
    logic       asrc;
    logic [1:0] gpr, wd;
    logic       berr;
  } obs_t;

  typedef struct {
    obs_t        e;
    int unsigned ret;
    string       tag;
  } rec_t;

  typedef enum int {
    K_R, K_I, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_JR, K_JALR, K_NOP
  } kind_e;

  typedef struct {
    string      nm;
    logic [5:0] op, fn;
    kind_e      k;
    logic [3:0] alu;
    logic [1:0] bs;
    logic       ar, ext;
  } ins_t;

  rec_t        sb[$];
  rec_t        mc;
  obs_t        act;
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_ret = 0;
  string       cur_tag = "reset";

  function automatic ins_t mk(string nm, logic [5:0] op, logic [5:0] fn,
                              kind_e k, logic [3:0] alu, logic [1:0] bs,
                              logic ar, logic ext);
    ins_t i;
    i.nm = nm; i.op = op; i.fn = fn; i.k = k;
    i.alu = alu; i.bs = bs; i.ar = ar; i.ext = ext;
    return i;
  endfunction

  function automatic ins_t ins(int sel);
    case (sel)
      0:  return mk("addu", 6'h00, 6'h21, K_R, ALU_ADD, 2'b00, 0, 0);
      1:  return mk("subu", 6'h00, 6'h23, K_R, ALU_SUB, 2'b00, 0, 0);
      2:  return mk("and", 6'h00, 6'h24, K_R, ALU_AND, 2'b00, 0, 0);
      3:  return mk("or", 6'h00, 6'h25, K_R, ALU_OR, 2'b00, 0, 0);
      4:  return mk("xor", 6'h00, 6'h26, K_R, ALU_XOR, 2'b00, 0, 0);
      5:  return mk("nor", 6'h00, 6'h27, K_R, ALU_NOR, 2'b00, 0, 0);
      6:  return mk("slt", 6'h00, 6'h2a, K_R, ALU_SLT, 2'b00, 0, 0);
      7:  return mk("sltu", 6'h00, 6'h2b, K_R, ALU_SLTU, 2'b00, 0, 0);
      8:  return mk("sll", 6'h00, 6'h00, K_R, ALU_SLL, 2'b10, 1, 0);
      9:  return mk("srl", 6'h00, 6'h02, K_R, ALU_SRL, 2'b10, 1, 0);
      10: return mk("sra", 6'h00, 6'h03, K_R, ALU_SRA, 2'b10, 1, 0);
      11: return mk("addi", 6'h08, 6'h15, K_I, ALU_ADD, 2'b01, 0, 1);
      12: return mk("andi", 6'h0c, 6'h3f, K_I, ALU_AND, 2'b01, 0, 0);
      13: return mk("ori", 6'h0d, 6'h09, K_I, ALU_OR, 2'b01, 0, 0);
      14: return mk("slti", 6'h0a, 6'h08, K_I, ALU_SLT, 2'b01, 0, 1);
      15: return mk("lui", 6'h0f, 6'h21, K_LUI, ALU_LUI, 2'b01, 0, 0);
      16: return mk("lw", 6'h23, 6'h08, K_LW, ALU_ADD, 2'b01, 0, 1);
      17: return mk("sw", 6'h2b, 6'h09, K_SW, ALU_ADD, 2'b01, 0, 1);
      18: return mk("beq", 6'h04, 6'h00, K_BEQ, ALU_SUB, 2'b00, 0, 0);
      19: return mk("bne", 6'h05, 6'h21, K_BNE, ALU_SUB, 2'b00, 0, 0);
      20: return mk("j", 6'h02, 6'h08, K_J, ALU_ADD, 2'b00, 0, 0);
      21: return mk("jal", 6'h03, 6'h00, K_JAL, ALU_ADD, 2'b00, 0, 0);
      22: return mk("jr", 6'h00, 6'h08, K_JR, ALU_ADD, 2'b00, 0, 0);
      23: return mk("jalr", 6'h00, 6'h09, K_JALR, ALU_ADD, 2'b00, 0, 0);
      24: return mk("badop", 6'h3f, 6'h21, K_NOP, ALU_ADD, 2'b00, 0, 0);
      25: return mk("badfn", 6'h00, 6'h3f, K_NOP, ALU_ADD, 2'b00, 0, 0);
      26: return mk("add", 6'h00, 6'h20, K_R, ALU_ADD, 2'b00, 0, 0);
      default:
          return mk("sub", 6'h00, 6'h22, K_R, ALU_SUB, 2'b00, 0, 0);
    endcase
  endfunction

  function automatic obs_t blank(logic [2:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t alu_obs(ins_t i, logic [2:0] st);
    obs_t o = blank(st);
    o.alu = i.alu; o.bsel = i.bs; o.asrc = i.ar; o.ext = i.ext;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic r, input logic ir, input logic dr,
                      input obs_t ev);
    rst = r; imem_ready = ir; dmem_ready = dr;
    sb.push_back('{e: ev, ret: (r ? 0 : exp_ret), tag: cur_tag});
    if (r) exp_ret = 0;
    @(posedge clk); #1;
  endtask

  task automatic err_tail();
    obs_t ev;
    for (int k = 0; k < 3; k++) begin
      ev = blank(3'b101);
      ev.berr = 1'b1;
      step(0, rb(), rb(), ev);
    end
    step(1, rb(), rb(), blank(3'b000));
  endtask

  // One instruction: wi/wd = ready delays (>= TOM times out),
  // rmid = assert reset after the first MEM cycle
  task automatic run(input ins_t i, input int wi, input int wd,
                     input logic z, input bit rmid);
    obs_t ev;
    cur_tag = i.nm;
    Op = i.op; Funct = i.fn; Zero = z;
    for (int k = 0; k < ((wi < TOM) ? wi : TOM); k++) begin
      ev = blank(3'b000); ev.ireq = 1'b1;
      step(0, 0, rb(), ev);
    end
    if (wi >= TOM) begin err_tail(); return; end
    ev = blank(3'b000); ev.ireq = 1'b1; ev.irw = 1'b1; ev.pcw = 1'b1;
    step(0, 1, rb(), ev);
    ev = blank(3'b001);
    if (i.k inside {K_J, K_JAL, K_JR, K_JALR}) begin
      ev.pcw = 1'b1;
      ev.npc = (i.k inside {K_J, K_JAL}) ? 2'b10 : 2'b11;
      if (i.k inside {K_JAL, K_JALR}) begin
        ev.rw = 1'b1;
        ev.wd = 2'b10;
        ev.gpr = (i.k == K_JAL) ? 2'b10 : 2'b00;
      end
      step(0, rb(), rb(), ev);
      exp_ret++;
      return;
    end
    step(0, rb(), rb(), ev);
    ev = alu_obs(i, 3'b010);
    if (i.k inside {K_BEQ, K_BNE}) begin
      ev.pcw = (i.k == K_BEQ) ? z : ~z;
      ev.npc = 2'b01;
      step(0, rb(), rb(), ev);
      exp_ret++;
      return;
    end
    step(0, rb(), rb(), ev);
    if (i.k inside {K_LW, K_SW}) begin
      ev = alu_obs(i, 3'b011);
      ev.dreq = 1'b1;
      ev.mw = (i.k == K_SW);
      if (rmid) begin
        step(0, rb(), 0, ev);
        step(1, rb(), rb(), blank(3'b000));
        return;
      end
      for (int k = 0; k < ((wd < TOM) ? wd : TOM); k++)
        step(0, rb(), 0, ev);
      if (wd >= TOM) begin err_tail(); return; end
      step(0, rb(), 1, ev);
      if (i.k == K_SW) begin exp_ret++; return; end
    end
    ev = alu_obs(i, 3'b100);
    ev.rw = (i.k != K_NOP);
    ev.gpr = (i.k inside {K_I, K_LUI, K_LW}) ? 2'b01 : 2'b00;
    ev.wd = (i.k == K_LW) ? 2'b01 : (i.k == K_LUI) ? 2'b11 : 2'b00;
    step(0, rb(), rb(), ev);
    exp_ret++;
  endtask

  // Scoreboard monitor: one expected record per cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mc = sb.pop_front();
      act = {state, imem_req, dmem_req, IRWrite, PCWrite, RegWrite,
             MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc, ASrc, GPRSel,
             WDSel, bus_err};
      checks++;
      if (act !== mc.e) begin
        failures++;
        $display("FAIL %s t=%0t: got st=%0d vec=%h, expected st=%0d vec=%h",
                 mc.tag, $time, act.st, act, mc.e.st, mc.e);
      end
`ifdef MC_CTRL_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== mc.ret) begin
        failures++;
        $display("FAIL retire_cnt %s t=%0t: got %0d, expected %0d",
                 mc.tag, $time, retire_cnt, mc.ret);
      end
`endif
    end
  end

  initial begin
    @(posedge clk); #1;
    step(1, 0, 0, blank(3'b000));
    step(1, 1, 1, blank(3'b000));
    run(ins(0), 2, 0, 0, 0);
    run(ins(16), 0, 2, 0, 0);
    run(ins(18), 0, 0, 1, 0);
    run(ins(19), 0, 0, 1, 0);
    run(ins(21), 0, 0, 0, 0);
    run(ins(0), 3, 0, 0, 0);
    run(ins(17), 1, 3, 0, 0);
    run(ins(0), TOM, 0, 0, 0);
    run(ins(22), 0, 0, 0, 0);
    run(ins(16), 0, TOM, 0, 0);
    run(ins(23), 0, 0, 0, 0);
    run(ins(17), 0, 0, 0, 1);
    run(ins(15), 0, 0, 0, 0);
    run(ins(24), 0, 0, 0, 0);
    for (int n = 0; n < 300; n++)
      run(ins(int'($urandom_range(0, 27))),
          int'($urandom_range(0, TOM - 1)),
          int'($urandom_range(0, TOM - 1)), rb(), 0);
    cur_tag = "drain";
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
